// File: rtl/plru_state_tracker.sv
// plru_state_tracker: per-set 4-way tree-PLRU state store.
// ALLOC returns the victim way and advances the tree; TOUCH makes a hit way MRU.
// Tree bits per set are {L2,L1,L0}: L2 = root, L1 = ways 0/1, L0 = ways 2/3.
// Optional feature macro: PLRU_BYPASS_EN. When it is defined, an alloc and a
// touch to the same set in one cycle are serialised touch-then-alloc. When it
// is not defined, the touch is dropped and touch_dropped_o pulses.
module plru_state_tracker #(
    parameter int NUM_SETS  = 16,
    parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 ready_o,
    input  logic                 alloc_valid_i,
    input  logic [SET_IDX_W-1:0] alloc_set_i,
    output logic                 alloc_resp_valid_o,
    output logic [1:0]           alloc_way_o,
    input  logic                 touch_valid_i,
    input  logic [SET_IDX_W-1:0] touch_set_i,
    input  logic [1:0]           touch_way_i,
    output logic                 touch_dropped_o,
    input  logic                 flush_req_i,
    output logic                 flush_done_o
);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

    // Victim is the way the tree points away from.
    function automatic logic [1:0] alloc_victim(input logic [2:0] s);
        return s[2] ? {1'b0, ~s[1]} : {1'b1, ~s[0]};
    endfunction

    // Point the tree away from way w; only the root and w's pair bit change.
    function automatic logic [2:0] touch_next(input logic [2:0] s, input logic [1:0] w);
        return w[1] ? {1'b1, s[1], w[0]} : {1'b0, w[0], s[0]};
    endfunction

    state_e                 fsm_q;
    logic                   ready_q;
    logic [SET_IDX_W-1:0]   flush_idx_q;
    logic                   resp_valid_q;
    logic [1:0]             way_q;
    logic                   dropped_q;
    logic                   done_q;

    logic [2:0]             plru_q [NUM_SETS];
    logic [2:0]             plru_d [NUM_SETS];

    logic                   same_set;
    logic [2:0]             alloc_cur;
    logic [2:0]             alloc_src;
    logic [1:0]             victim;
    logic                   conflict_drop;

    // Victim selection and next-state of the whole tree array.
    always_comb begin
        same_set  = (alloc_set_i == touch_set_i);
        alloc_cur = plru_q[alloc_set_i];
`ifdef PLRU_BYPASS_EN
        // Same-set touch is folded in ahead of the alloc, so the hit way is protected.
        alloc_src     = (touch_valid_i && same_set) ? touch_next(alloc_cur, touch_way_i) : alloc_cur;
        conflict_drop = 1'b0;
`else
        // Alloc sees the pre-touch state; its write below overrides the touch.
        alloc_src     = alloc_cur;
        conflict_drop = alloc_valid_i && touch_valid_i && same_set;
`endif
        victim = alloc_victim(alloc_src);

        plru_d = plru_q;
        if (fsm_q == ST_FLUSH) begin
            plru_d[flush_idx_q] = 3'b000;
        end else if (ready_q) begin
            if (touch_valid_i)
                plru_d[touch_set_i] = touch_next(plru_q[touch_set_i], touch_way_i);
            // Alloc write last: on a same-set collision it is the value that sticks.
            if (alloc_valid_i)
                plru_d[alloc_set_i] = touch_next(alloc_src, victim);
        end
    end

    // Tree state storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SETS; i++) plru_q[i] <= 3'b000;
        end else begin
            plru_q <= plru_d;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q        <= ST_IDLE;
            ready_q      <= 1'b1;
            flush_idx_q  <= '0;
            resp_valid_q <= 1'b0;
            way_q        <= 2'd0;
            dropped_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            dropped_q    <= 1'b0;
            done_q       <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (alloc_valid_i) begin
                        resp_valid_q <= 1'b1;
                        way_q        <= victim;
                        dropped_q    <= conflict_drop;
                    end
                    if (flush_req_i) begin
                        fsm_q       <= ST_FLUSH;
                        ready_q     <= 1'b0;
                        flush_idx_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    flush_idx_q <= flush_idx_q + 1'b1;
                    // Raise done so it is visible during the cycle the last set is cleared.
                    if (flush_idx_q == SET_IDX_W'(NUM_SETS - 2))
                        done_q <= 1'b1;
                    if (flush_idx_q == SET_IDX_W'(NUM_SETS - 1)) begin
                        fsm_q       <= ST_IDLE;
                        ready_q     <= 1'b1;
                        flush_idx_q <= '0;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o            = ready_q;
    assign alloc_resp_valid_o = resp_valid_q;
    assign alloc_way_o        = way_q;
    assign touch_dropped_o    = dropped_q;
    assign flush_done_o       = done_q;

endmodule

// File: tb/tb_plru_state_tracker.sv
// tb_plru_state_tracker: randomized and directed bench for plru_state_tracker.
// The reference model tracks, per set, which half was used last and which way
// inside each half was used last; the victim is always the least recent side.
module tb_plru_state_tracker;

    localparam int NUM_SETS = 16;
    localparam int SW       = $clog2(NUM_SETS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready;
    logic          alloc_valid = 1'b0;
    logic [SW-1:0] alloc_set = '0;
    logic          resp_valid;
    logic [1:0]    alloc_way;
    logic          touch_valid = 1'b0;
    logic [SW-1:0] touch_set = '0;
    logic [1:0]    touch_way = '0;
    logic          touch_dropped;
    logic          flush_req = 1'b0;
    logic          flush_done;

    int n_checks = 0;
    int n_fail   = 0;

    plru_state_tracker #(.NUM_SETS(NUM_SETS)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .ready_o            (ready),
        .alloc_valid_i      (alloc_valid),
        .alloc_set_i        (alloc_set),
        .alloc_resp_valid_o (resp_valid),
        .alloc_way_o        (alloc_way),
        .touch_valid_i      (touch_valid),
        .touch_set_i        (touch_set),
        .touch_way_i        (touch_way),
        .touch_dropped_o    (touch_dropped),
        .flush_req_i        (flush_req),
        .flush_done_o       (flush_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   last_half  [NUM_SETS];   // 0: left pair used last, 1: right pair used last
    int   last_left  [NUM_SETS];   // way (0/1) used last in left pair
    int   last_right [NUM_SETS];   // way offset (0/1) used last in right pair
    logic [1:0] last_way;

    task automatic m_clear();
        for (int i = 0; i < NUM_SETS; i++) begin
            last_half[i] = 0; last_left[i] = 0; last_right[i] = 0;
        end
        last_way = 2'd0;
    endtask

    function automatic int m_victim(input int s);
        if (last_half[s] == 1) return 1 - last_left[s];
        return 3 - last_right[s];
    endfunction

    task automatic m_touch(input int s, input int w);
        if (w >= 2) begin last_half[s] = 1; last_right[s] = w - 2; end
        else        begin last_half[s] = 0; last_left[s]  = w;     end
    endtask

    // Drive one accepted cycle, advance the model, return expected outputs after the edge.
    task automatic do_op(input bit av, input int as, input bit tv, input int ts, input int tw,
                         output logic ev, output logic [1:0] ew, output logic ed);
        int v;
        alloc_valid = av; alloc_set = SW'(as);
        touch_valid = tv; touch_set = SW'(ts); touch_way = 2'(tw);
        ed = 1'b0;
        if (av && tv && as == ts) begin
`ifdef PLRU_BYPASS_EN
            m_touch(ts, tw);
            v = m_victim(as);
            m_touch(as, v);
`else
            v = m_victim(as);
            m_touch(as, v);
            ed = 1'b1;
`endif
            last_way = 2'(v);
        end else begin
            if (tv) m_touch(ts, tw);
            if (av) begin
                v = m_victim(as);
                m_touch(as, v);
                last_way = 2'(v);
            end
        end
        ev = av;
        ew = last_way;
        @(posedge clk); #1;
        alloc_valid = 1'b0; touch_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #10;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (ready !== 1'b1 || resp_valid !== 1'b0 || alloc_way !== 2'd0 ||
            touch_dropped !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy=%b rv=%b way=%0d drop=%b done=%b want 1 0 0 0 0",
                     ready, resp_valid, alloc_way, touch_dropped, flush_done);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_clear();
    endtask

    task automatic test_alloc_seq();
        logic ev, ed; logic [1:0] ew;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 0, 1'b0, 0, 0, ev, ew, ed);
            n_checks++;
            if (resp_valid !== ev || alloc_way !== ew) begin
                n_fail++;
                $display("FAIL alloc_seq[%0d]: got rv=%b way=%0d want rv=%b way=%0d", i, resp_valid, alloc_way, ev, ew);
            end
        end
        // Response is a single-cycle pulse, way holds.
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || alloc_way !== ew) begin
            n_fail++;
            $display("FAIL alloc_hold: got rv=%b way=%0d want rv=0 way=%0d", resp_valid, alloc_way, ew);
        end
    endtask

    task automatic test_touch();
        logic ev, ed; logic [1:0] ew;
        apply_reset();
        do_op(1'b0, 0, 1'b1, 5, 1, ev, ew, ed);
        do_op(1'b1, 5, 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (alloc_way !== ew || ew == 2'd1) begin
            n_fail++;
            $display("FAIL touch_way1: got way=%0d want %0d (not 1)", alloc_way, ew);
        end
        do_op(1'b0, 0, 1'b1, 6, 2, ev, ew, ed);
        do_op(1'b1, 6, 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (alloc_way !== ew) begin
            n_fail++;
            $display("FAIL touch_way2: got way=%0d want %0d", alloc_way, ew);
        end
    endtask

    task automatic test_dual_diff();
        logic ev, ed; logic [1:0] ew;
        apply_reset();
        do_op(1'b1, 2, 1'b1, 7, 0, ev, ew, ed);
        n_checks++;
        if (resp_valid !== 1'b1 || alloc_way !== ew || touch_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_diff: got rv=%b way=%0d drop=%b want 1 %0d 0", resp_valid, alloc_way, touch_dropped, ew);
        end
        do_op(1'b1, 7, 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (alloc_way !== ew) begin
            n_fail++;
            $display("FAIL dual_diff probe set7: got way=%0d want %0d", alloc_way, ew);
        end
        do_op(1'b1, 2, 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (alloc_way !== ew) begin
            n_fail++;
            $display("FAIL dual_diff probe set2: got way=%0d want %0d", alloc_way, ew);
        end
    endtask

    task automatic test_same_set();
        logic ev, ed; logic [1:0] ew;
        apply_reset();
        do_op(1'b1, 4, 1'b1, 4, 3, ev, ew, ed);
        n_checks++;
        if (resp_valid !== 1'b1 || alloc_way !== ew || touch_dropped !== ed) begin
            n_fail++;
            $display("FAIL same_set: got way=%0d drop=%b want way=%0d drop=%b", alloc_way, touch_dropped, ew, ed);
        end
        do_op(1'b1, 4, 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (alloc_way !== ew || touch_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL same_set probe: got way=%0d drop=%b want %0d 0", alloc_way, touch_dropped, ew);
        end
    endtask

    task automatic test_random();
        logic ev, ed; logic [1:0] ew;
        int errs = 0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom_range(1)), int'($urandom_range(3)),
                  1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)), ev, ew, ed);
            n_checks++;
            if (resp_valid !== ev || alloc_way !== ew || touch_dropped !== ed) begin
                n_fail++;
                if (errs++ < 5)
                    $display("FAIL random[%0d]: got rv=%b way=%0d drop=%b want rv=%b way=%0d drop=%b",
                             i, resp_valid, alloc_way, touch_dropped, ev, ew, ed);
            end
        end
    endtask

    task automatic test_flush();
        logic ev, ed; logic [1:0] ew;
        int low = 0;
        apply_reset();
        for (int i = 0; i < 12; i++)
            do_op(1'b1, int'($urandom_range(NUM_SETS-1)), 1'b1, int'($urandom_range(NUM_SETS-1)),
                  int'($urandom_range(3)), ev, ew, ed);
        // Alloc issued with the flush request is still served.
        flush_req = 1'b1;
        do_op(1'b1, 3, 1'b0, 0, 0, ev, ew, ed);
        flush_req = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || alloc_way !== ew || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start: got rv=%b way=%0d rdy=%b want 1 %0d 0", resp_valid, alloc_way, ready, ew);
        end
        if (ready === 1'b0) low++;
        for (int k = 1; k <= 16; k++) begin
            alloc_valid = 1'b1; alloc_set = SW'($urandom_range(NUM_SETS-1));
            touch_valid = 1'b1; touch_set = SW'($urandom_range(NUM_SETS-1)); touch_way = 2'($urandom_range(3));
            @(posedge clk); #1;
            alloc_valid = 1'b0; touch_valid = 1'b0;
            if (ready === 1'b0) low++;
            n_checks++;
            if (ready !== (k >= 16) || flush_done !== (k == 15) || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_cycle[%0d]: got rdy=%b done=%b rv=%b want %b %b 0",
                         k + 1, ready, flush_done, resp_valid, (k >= 16), (k == 15));
            end
        end
        n_checks++;
        if (low != NUM_SETS) begin
            n_fail++;
            $display("FAIL flush_len: got %0d ready-low cycles want %0d", low, NUM_SETS);
        end
        m_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            do_op(1'b1, s, 1'b0, 0, 0, ev, ew, ed);
            n_checks++;
            if (alloc_way !== ew) begin
                n_fail++;
                $display("FAIL flush_clear set%0d: got way=%0d want %0d", s, alloc_way, ew);
            end
        end
    endtask

    task automatic test_flush_reset();
        logic ev, ed; logic [1:0] ew;
        int bad = 0;
        for (int i = 0; i < 6; i++)
            do_op(1'b1, int'($urandom_range(NUM_SETS-1)), 1'b0, 0, 0, ev, ew, ed);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || flush_done !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_reset immediate: got rdy=%b done=%b rv=%b want 1 0 0", ready, flush_done, resp_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_clear();
        for (int k = 0; k < 20; k++) begin
            if (flush_done !== 1'b0 || ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL flush_reset idle: got %0d cycles with done=1 or rdy=0 want 0", bad);
        end
        do_op(1'b1, int'($urandom_range(NUM_SETS-1)), 1'b0, 0, 0, ev, ew, ed);
        n_checks++;
        if (resp_valid !== 1'b1 || alloc_way !== ew) begin
            n_fail++;
            $display("FAIL flush_reset alloc: got rv=%b way=%0d want 1 %0d", resp_valid, alloc_way, ew);
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_alloc_seq();
        test_touch();
        test_dual_diff();
        test_same_set();
        test_random();
        test_flush();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
